// File: rtl/sqrt_req_ctrl_pkg.sv
// Shared defaults and FSM state encoding for the a_sqrtb requester.
package sqrt_req_ctrl_pkg;

  localparam int unsigned DEF_A_W     = 8;
  localparam int unsigned DEF_B_W     = 8;
  localparam int unsigned DEF_Y_W     = 12;
  localparam int unsigned DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/sqrt_timeout_ctr.sv
// Response timer: clear/enable counter that stops at TIMEOUT-1 and flags the terminal count.
module sqrt_timeout_ctr
  import sqrt_req_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term_c
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  assign term_c = (cnt == CW'(TIMEOUT - 1));

  // Saturates at the terminal count rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !term_c) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sqrt_req_ctrl.sv
// Requester side of the a_sqrtb handshake: one operand pair in flight, with
// timeout recovery and sticky detection of responses arriving outside WAIT.
module sqrt_req_ctrl
  import sqrt_req_ctrl_pkg::*;
#(
  parameter int unsigned A_W     = DEF_A_W,
  parameter int unsigned B_W     = DEF_B_W,
  parameter int unsigned Y_W     = DEF_Y_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [A_W-1:0] s_a,
  input  logic [B_W-1:0] s_b,
  output logic [A_W-1:0] core_a,
  output logic [B_W-1:0] core_b,
  output logic           core_in_ready,
  input  logic [Y_W-1:0] core_y,
  input  logic           core_y_ready,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [Y_W-1:0] m_y,
  output logic [A_W-1:0] m_a,
  output logic [B_W-1:0] m_b,
  output logic           m_timeout,
  output logic           busy,
  output logic           err_stray
);

  state_e state;
  logic   tmr_term;

  // Gated by rst so upstream never sees ready while the block is held in reset.
  assign s_ready = (state == ST_IDLE) && !rst;

  sqrt_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ST_ISSUE),
    .en     (state == ST_WAIT),
    .term_c (tmr_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      core_a        <= '0;
      core_b        <= '0;
      core_in_ready <= 1'b0;
      m_valid       <= 1'b0;
      m_y           <= '0;
      m_a           <= '0;
      m_b           <= '0;
      m_timeout     <= 1'b0;
      busy          <= 1'b0;
      err_stray     <= 1'b0;
    end else begin
      // Any response not expected in WAIT, including late ones after a timeout.
      if (core_y_ready && (state != ST_WAIT)) begin
        err_stray <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (s_valid) begin
            core_a        <= s_a;
            core_b        <= s_b;
            m_a           <= s_a;
            m_b           <= s_b;
            core_in_ready <= 1'b1;
            busy          <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          core_in_ready <= 1'b0;
          state         <= ST_WAIT;
        end
        ST_WAIT: begin
          // A response on the terminal cycle beats the timeout.
          if (core_y_ready) begin
            m_y       <= core_y;
            m_timeout <= 1'b0;
            m_valid   <= 1'b1;
            state     <= ST_HOLD;
          end else if (tmr_term) begin
            m_y       <= '1;
            m_timeout <= 1'b1;
            m_valid   <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
